// File: rtl/rs_stream_encoder.sv
// ---------------------------------------------------------------------------
// rs_stream_encoder
//
// Streaming systematic Reed-Solomon encoder RS(N,K) over GF(2^M). The encoder
// accepts one message symbol per beat and passes it straight through. It also
// divides the message by g(x) using an LFSR. After the K-th data symbol it
// emits the N-K remainder (parity) symbols, highest degree first. g(x) is
// built at elaboration time from PRIM_POLY and FCR.
//
// Parameters
//   M          symbol width in bits (3..8)
//   N          codeword length in symbols (N <= 2^M-1)
//   K          data symbols per codeword (N-K even, >= 2)
//   PRIM_POLY  field primitive polynomial, x^M term included
//   FCR        first consecutive root; g(x) = prod_{i<N-K} (x - a^(FCR+i))
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   s_valid   input symbol valid
//   s_ready   encoder accepts s_data this cycle
//   s_data    message symbol; first accepted = highest-degree coefficient
//   m_valid   output symbol valid
//   m_ready   downstream accepts m_data
//   m_data    codeword symbol
//   m_parity  m_data is a parity symbol
//   m_last    m_data is the final parity symbol of the codeword
// ---------------------------------------------------------------------------
module rs_stream_encoder #(
  parameter int M         = 4,
  parameter int N         = 15,
  parameter int K         = 11,
  parameter int PRIM_POLY = 19,
  parameter int FCR       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [M-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [M-1:0] m_data,
  output logic         m_parity,
  output logic         m_last
);

  localparam int P     = N - K;
  localparam int SYM_W = $clog2(K + 1);
  localparam int PAR_W = $clog2(P + 1);
  localparam int MP1   = M + 1;
  localparam logic [M:0] POLY = MP1'(PRIM_POLY);

  // Elaboration-time parameter sanity checks.
  if (M < 3 || M > 8) begin : g_bad_m
    $error("rs_stream_encoder: M must be 3..8");
  end
  if (N > (1 << M) - 1 || K < 1 || K >= N) begin : g_bad_nk
    $error("rs_stream_encoder: need 1 <= K < N <= 2^M-1");
  end
  if ((P % 2) != 0 || P < 2) begin : g_bad_p
    $error("rs_stream_encoder: N-K must be even and >= 2");
  end

  // -------------------------------------------------------------------------
  // GF(2^M) arithmetic
  // -------------------------------------------------------------------------
  // Multiply by alpha (x), reducing modulo the primitive polynomial.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    logic [M:0] t;
    t = {a, 1'b0};
    if (t[M]) t = t ^ POLY;
    return t[M-1:0];
  endfunction

  // Shift-and-add multiply. It is evaluated at elaboration time to build
  // g(x). In hardware one operand is a constant, so it folds into an XOR tree.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Expand g(x) = prod (x + a^(FCR+i)). The result is returned as the packed
  // low-order coefficients g_0..g_{P-1}. The leading coefficient g_P is 1 and
  // is implicit in the LFSR feedback.
  function automatic logic [P*M-1:0] gen_poly();
    logic [(P+1)*M-1:0] c;
    logic [M-1:0]       root;
    c          = '0;
    c[0 +: M]  = M'(1);
    root       = M'(1);
    for (int k = 0; k < FCR; k++) root = xtime(root);
    for (int i = 0; i < P; i++) begin
      for (int j = P; j >= 1; j--) begin
        c[j*M +: M] = c[(j-1)*M +: M] ^ gf_mul(c[j*M +: M], root);
      end
      c[0 +: M] = gf_mul(c[0 +: M], root);
      root      = xtime(root);
    end
    return c[P*M-1:0];
  endfunction

  localparam logic [P*M-1:0] G = gen_poly();

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic {
    S_DATA,
    S_PARITY
  } state_t;

  state_t             state,   state_d;
  logic [SYM_W-1:0]   sym_cnt, sym_cnt_d;
  logic [PAR_W-1:0]   par_cnt, par_cnt_d;
  logic [M-1:0]       p   [P];
  logic [M-1:0]       p_d [P];
  logic [M-1:0]       m_data_d;
  logic               m_valid_d;
  logic               m_parity_d;
  logic               m_last_d;

  logic               slot_free;
  logic               last_par;
  logic [M-1:0]       fb;

  // The output register can take a new symbol when it is empty, or when it
  // is draining this cycle.
  assign slot_free = !m_valid || m_ready;
  assign s_ready   = !rst && (state == S_DATA) && slot_free;
  assign last_par  = (par_cnt == PAR_W'(P - 1));
  // fb is used only on a handshake, so stray X on an idle s_data goes nowhere.
  assign fb        = s_data ^ p[P-1];

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d    = state;
    sym_cnt_d  = sym_cnt;
    par_cnt_d  = par_cnt;
    p_d        = p;
    m_data_d   = m_data;
    m_valid_d  = m_valid;
    m_parity_d = m_parity;
    m_last_d   = m_last;

    case (state)
      S_DATA: begin
        if (s_valid && s_ready) begin
          m_data_d   = s_data;
          m_valid_d  = 1'b1;
          m_parity_d = 1'b0;
          m_last_d   = 1'b0;
          // One step of polynomial division by g(x).
          p_d[0] = gf_mul(G[0 +: M], fb);
          for (int j = 1; j < P; j++) begin
            p_d[j] = p[j-1] ^ gf_mul(G[j*M +: M], fb);
          end
          if (sym_cnt == SYM_W'(K - 1)) begin
            state_d   = S_PARITY;
            sym_cnt_d = '0;
          end else begin
            sym_cnt_d = sym_cnt + 1'b1;
          end
        end else if (slot_free) begin
          // The slot drains and nothing replaces it.
          m_valid_d  = 1'b0;
          m_parity_d = 1'b0;
          m_last_d   = 1'b0;
        end
      end

      S_PARITY: begin
        // Under backpressure nothing moves: no shift and no count.
        if (slot_free) begin
          m_data_d   = p[P-1];
          m_valid_d  = 1'b1;
          m_parity_d = 1'b1;
          m_last_d   = last_par;
          p_d[0]     = '0;
          for (int j = 1; j < P; j++) begin
            p_d[j] = p[j-1];
          end
          if (last_par) begin
            state_d   = S_DATA;
            par_cnt_d = '0;
            for (int j = 0; j < P; j++) begin
              p_d[j] = '0;
            end
          end else begin
            par_cnt_d = par_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_DATA;
      sym_cnt  <= '0;
      par_cnt  <= '0;
      // NOTE: the parity array is a handful of LFSR flops, not a RAM. A
      // reset-time clear guarantees that the codeword after a mid-stream
      // reset starts from a zero remainder.
      for (int j = 0; j < P; j++) begin
        p[j] <= '0;
      end
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_parity <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values computed above.
      state    <= state_d;
      sym_cnt  <= sym_cnt_d;
      par_cnt  <= par_cnt_d;
      p        <= p_d;
      m_data   <= m_data_d;
      m_valid  <= m_valid_d;
      m_parity <= m_parity_d;
      m_last   <= m_last_d;
    end
  end

endmodule
